sm_als_spi: RTL and testbench



---
 rtl/sm_als_spi.sv | 132 +++++++++++++
 tb/tb_sm_als_spi.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sm_als_spi.sv
// SPI master for the ADC081S021-type ambient light sensor: frames 16 SCK cycles,
// captures the 8-bit sample and supports single-shot and periodic conversion.
module sm_als_spi #(
   parameter int SCK_DIV  = 8,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2,
   parameter int PERIOD   = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        autoEn,
   output logic        busy,
   output logic        valid,
   output logic [7:0]  value,
   output logic [15:0] sampleCnt,
   output logic        alsCS,
   output logic        alsSCK,
   input  logic        alsSDO
);

   localparam int CW = 16;
   localparam int PW = $clog2(PERIOD + 1);
   localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
   localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
   localparam logic [CW-1:0] HALF_LAST  = CW'(SCK_DIV - 1);
   localparam logic [PW-1:0] PER_LAST   = PW'(PERIOD - 1);

   typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD} stateT;

   stateT          state;
   logic [CW-1:0]  cnt;
   logic [3:0]     bitCnt;
   logic [15:0]    sh;
   logic [PW-1:0]  perCnt;
   logic           sdoMeta;
   logic           sdoS;
   logic           autoDue;

   // The period counter saturates at its last value, so an expiry during a
   // frame stays pending until the FSM returns to IDLE.
   assign autoDue = autoEn && (perCnt == PER_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         sdoMeta   <= 1'b0;
         sdoS      <= 1'b0;
         state     <= IDLE;
         cnt       <= '0;
         bitCnt    <= '0;
         sh        <= '0;
         perCnt    <= '0;
         busy      <= 1'b0;
         valid     <= 1'b0;
         value     <= '0;
         sampleCnt <= '0;
         alsCS     <= 1'b1;
         alsSCK    <= 1'b1;
      end else begin
         sdoMeta <= alsSDO;
         sdoS    <= sdoMeta;
         valid   <= 1'b0;

         if (!autoEn)
            perCnt <= '0;
         else if (perCnt != PER_LAST)
            perCnt <= perCnt + 1'b1;

         case (state)
            IDLE: begin
               if (start || autoDue) begin
                  state  <= SETUP;
                  cnt    <= '0;
                  bitCnt <= '0;
                  perCnt <= '0;
                  alsCS  <= 1'b0;
                  alsSCK <= 1'b1;
                  busy   <= 1'b1;
               end
            end
            SETUP: begin
               if (cnt == SETUP_LAST) begin
                  state  <= LOW;
                  cnt    <= '0;
                  alsSCK <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            LOW: begin
               if (cnt == HALF_LAST) begin
                  state  <= HIGH;
                  cnt    <= '0;
                  alsSCK <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HIGH: begin
               if (cnt == HALF_LAST) begin
                  cnt    <= '0;
                  sh     <= {sh[14:0], sdoS};
                  bitCnt <= bitCnt + 1'b1;
                  if (bitCnt == 4'd15) begin
                     state <= HOLD;
                     alsCS <= 1'b1;
                  end else begin
                     state  <= LOW;
                     alsSCK <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HOLD: begin
               if (cnt == HOLD_LAST) begin
                  state     <= IDLE;
                  cnt       <= '0;
                  busy      <= 1'b0;
                  valid     <= 1'b1;
                  value     <= sh[12:5];
                  sampleCnt <= sampleCnt + 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sm_als_spi.sv
// Directed self-checking bench for sm_als_spi with a behavioural ADC081S021 model.
module tb_sm_als_spi;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        autoEn = 1'b0;
   logic        busy;
   logic        valid;
   logic [7:0]  value;
   logic [15:0] sampleCnt;
   logic        alsCS;
   logic        alsSCK;
   logic        alsSDO = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [15:0] sensWord = 16'h0000;
   int          modelCnt = 0;
   logic        modelPrevSck = 1'b1;

   sm_als_spi #(.SCK_DIV(8), .CS_SETUP(2), .CS_HOLD(2), .PERIOD(1024)) dut (
      .clk(clk), .rst(rst), .start(start), .autoEn(autoEn), .busy(busy),
      .valid(valid), .value(value), .sampleCnt(sampleCnt),
      .alsCS(alsCS), .alsSCK(alsSCK), .alsSDO(alsSDO)
   );

   always #5 clk = ~clk;

   // Sensor shifts out the next bit after each SCK falling edge while selected.
   always @(negedge clk) begin
      if (alsCS) begin
         modelCnt     = 0;
         modelPrevSck = 1'b1;
         alsSDO       = 1'b0;
      end else begin
         if (modelPrevSck && !alsSCK) begin
            if (modelCnt < 16) alsSDO = sensWord[15 - modelCnt];
            modelCnt++;
         end
         modelPrevSck = alsSCK;
      end
   end

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic pulseStart();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   // Entered at the negedge of cycle T+1; returns at the negedge of the valid cycle.
   task automatic watchFrame(output int busyCyc, output int lowCyc, output int falls,
                             output int validAt);
      logic prevSck;
      busyCyc = 0; lowCyc = 0; falls = 0; validAt = -1; prevSck = 1'b1;
      for (int k = 1; k <= 400 && validAt < 0; k++) begin
         if (k > 1) @(negedge clk);
         if (busy) busyCyc++;
         if (!alsSCK) lowCyc++;
         if (prevSck && !alsSCK) falls++;
         prevSck = alsSCK;
         if (valid) validAt = k;
      end
   endtask

   initial begin
      int bc, lc, fc, va, vcount, base, rises;
      int riseAt[8];
      logic prevBusy;

      // Reset values
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkVal("rst_cs", alsCS, 1);
      checkVal("rst_sck", alsSCK, 1);
      checkVal("rst_busy", busy, 0);
      checkVal("rst_valid", valid, 0);
      checkVal("rst_value", value, 0);
      checkVal("rst_cnt", sampleCnt, 0);

      // Single frame
      sensWord = {3'b000, 8'hA5, 5'b00000};
      pulseStart();
      checkVal("f1_cs_low", alsCS, 0);
      checkVal("f1_busy_t1", busy, 1);
      watchFrame(bc, lc, fc, va);
      checkVal("f1_busy_len", bc, 260);
      checkVal("f1_sck_low", lc, 128);
      checkVal("f1_falls", fc, 16);
      checkVal("f1_valid_at", va, 261);
      checkVal("f1_busy_end", busy, 0);
      checkVal("f1_value", value, 8'hA5);
      checkVal("f1_cnt", sampleCnt, 1);
      @(negedge clk);
      checkVal("f1_valid_1cyc", valid, 0);

      // start while busy is ignored
      sensWord = {3'b000, 8'h3C, 5'b10101};
      base = sampleCnt;
      vcount = 0;
      @(negedge clk) start = 1'b1;
      for (int k = 0; k < 600; k++) begin
         @(negedge clk);
         start = (k == 49 || k == 199);
         if (valid) vcount++;
      end
      checkVal("busy_valids", vcount, 1);
      checkVal("busy_cnt", sampleCnt, base + 1);
      checkVal("busy_value", value, 8'h3C);

      // Back-to-back: start in the valid cycle
      sensWord = {3'b000, 8'hFF, 5'b00000};
      pulseStart();
      watchFrame(bc, lc, fc, va);
      checkVal("b2b_v1_at", va, 261);
      checkVal("b2b_value1", value, 8'hFF);
      sensWord = 16'h0000;
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      checkVal("b2b_busy_next", busy, 1);
      checkVal("b2b_cs_next", alsCS, 0);
      watchFrame(bc, lc, fc, va);
      checkVal("b2b_v2_at", va, 261);
      checkVal("b2b_value2", value, 8'h00);
      checkVal("b2b_cnt", sampleCnt, base + 3);

      // Auto mode
      sensWord = {3'b000, 8'h5A, 5'b00000};
      base = sampleCnt;
      rises = 0;
      prevBusy = busy;
      autoEn = 1'b1;
      for (int k = 0; k < 5000; k++) begin
         @(negedge clk);
         if (busy && !prevBusy && rises < 8) begin
            riseAt[rises] = k;
            rises++;
         end
         prevBusy = busy;
      end
      autoEn = 1'b0;
      checkVal("auto_frames", rises, 4);
      checkVal("auto_int1", riseAt[1] - riseAt[0], 1024);
      checkVal("auto_int2", riseAt[2] - riseAt[1], 1024);
      checkVal("auto_int3", riseAt[3] - riseAt[2], 1024);
      checkVal("auto_cnt", sampleCnt, base + 4);
      checkVal("auto_value", value, 8'h5A);
      repeat (2500) @(negedge clk);
      checkVal("auto_off_cnt", sampleCnt, base + 4);
      checkVal("auto_off_busy", busy, 0);

      // Reset mid-frame
      sensWord = {3'b000, 8'h81, 5'b00000};
      pulseStart();
      repeat (99) @(negedge clk);
      rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      checkVal("mid_cs", alsCS, 1);
      checkVal("mid_sck", alsSCK, 1);
      checkVal("mid_valid", valid, 0);
      checkVal("mid_value", value, 0);
      checkVal("mid_busy", busy, 0);
      checkVal("mid_cnt", sampleCnt, 0);
      vcount = 0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (valid) vcount++;
      end
      checkVal("mid_no_valid", vcount, 0);

      // sampleCnt wrap
      force dut.sampleCnt = 16'hFFFF;
      @(negedge clk);
      release dut.sampleCnt;
      sensWord = {3'b000, 8'h42, 5'b11111};
      pulseStart();
      watchFrame(bc, lc, fc, va);
      checkVal("wrap_valid_at", va, 261);
      checkVal("wrap_cnt", sampleCnt, 16'h0000);
      checkVal("wrap_value", value, 8'h42);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
